// File: rtl/load_store_unit_if.sv
// Request, response and data-memory port bundle of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      input  rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
      output rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: one access at a time, big-endian lanes,
// read-modify-write for sub-word stores, rejects misaligned/reserved accesses.
module load_store_unit #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   load_store_unit_if.slave     bus,
   output logic [CNT_W-1:0]     acc_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               store_q, store_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [1:0]         lane_q, lane_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               mem_read_q, mem_read_d;
   logic               mem_write_q, mem_write_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]   acc_count_q, acc_count_d;

   function automatic logic access_bad(input logic [1:0] size, input logic [1:0] offs);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = offs[0];
         2'b10:   bad = offs[1] | offs[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Lane 0 is the most significant byte of the word.
   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      if (lane[1]) begin
         h = word[15:0];
      end else begin
         h = word[31:16];
      end
      case (size)
         2'b00:   r = {{24{~uns & b[7]}}, b};
         2'b01:   r = {{16{~uns & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00: begin
            case (lane)
               2'd0:    r[31:24] = wd[7:0];
               2'd1:    r[23:16] = wd[7:0];
               2'd2:    r[15:8]  = wd[7:0];
               default: r[7:0]   = wd[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) begin
               r[15:0] = wd[15:0];
            end else begin
               r[31:16] = wd[15:0];
            end
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      acc_count_d = acc_count_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               store_d = bus.req_store;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               lane_d  = bus.req_addr[1:0];
               wdata_d = bus.req_wdata;
               if (access_bad(bus.req_size, bus.req_addr[1:0])) begin
                  // Rejected accesses never reach memory.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = 32'h0000_0000;
               end else if (bus.req_store && (bus.req_size == 2'b10)) begin
                  state_d     = WRITE;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                  mem_wdata_d = bus.req_wdata;
               end else begin
                  state_d    = READ;
                  mem_read_d = 1'b1;
                  mem_addr_d = {bus.req_addr[31:2], 2'b00};
               end
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (store_q) begin
               state_d     = WRITE;
               mem_write_d = 1'b1;
               mem_wdata_d = merge_store(bus.mem_rdata, wdata_q, size_q, lane_q);
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = extract_load(bus.mem_rdata, size_q, lane_q, uns_q);
            end
         end
         WRITE: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = 32'h0000_0000;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               rsp_data_d  = 32'h0000_0000;
               acc_count_d = acc_count_q + CNT_W'(1);
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         store_q     <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= 32'h0000_0000;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
         acc_count_q <= '0;
      end else begin
         state_q     <= state_d;
         store_q     <= store_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         acc_count_q <= acc_count_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign acc_count     = acc_count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-array memory model, a reference
// model of the access rules, and one per-cycle compare process.
module tb_load_store_unit;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] acc_count;

   load_store_unit_if bus ();

   load_store_unit #(.CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .acc_count (acc_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] dmem    [0:63];
   logic [31:0] ref_mem [0:63];

   // Expectations published by the driver, consumed by the compare process.
   logic          started = 1'b0;
   logic          pending = 1'b0;
   logic          chk_rst = 1'b0;
   int            neg_cyc = 0;
   int            acc_neg = 0;
   int            exp_lat = 0;
   int            exp_rd = 0;
   int            exp_wr = 0;
   logic          exp_err = 1'b0;
   logic [31:0]   exp_data = 32'h0;
   logic [31:0]   exp_waddr = 32'h0;
   logic [31:0]   exp_wword = 32'h0;
   logic [CW-1:0] exp_acc = '0;
   logic          use_lit = 1'b0;
   logic [31:0]   lit = 32'h0;

   // Data memory: samples address/data mid-cycle, read data ready by next edge.
   always @(negedge clk) begin
      if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata <= dmem[bus.mem_addr[7:2]];
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, neg_cyc);
      end
   endtask

   // Reference model: big-endian lanes, shifts and masks on the whole word.
   task automatic model(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      int nb, sh;
      logic [63:0] m;
      logic [31:0] mask, w, raw;
      exp_err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
      exp_waddr = {a[31:2], 2'b00};
      exp_data  = 32'h0;
      exp_wword = 32'h0;
      if (exp_err) begin
         exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else begin
         nb   = 1 << int'(sz);
         sh   = (4 - nb - int'(a[1:0])) * 8;
         m    = (64'd1 << (nb * 8)) - 64'd1;
         mask = m[31:0];
         w    = ref_mem[a[7:2]];
         if (!st) begin
            raw = (w >> sh) & mask;
            if (!uns && raw[nb*8-1]) raw = raw | ~mask;
            exp_data = raw;
            exp_lat = 2; exp_rd = 1; exp_wr = 0;
         end else begin
            exp_wword = (w & ~(mask << sh)) | ((wd & mask) << sh);
            exp_lat = (nb == 4) ? 2 : 3;
            exp_rd  = (nb == 4) ? 0 : 1;
            exp_wr  = 1;
         end
      end
   endtask

   // Issue one request (called #1 after a rising edge with the DUT idle).
   task automatic access(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold, input logic [31:0] l);
      model(st, sz, uns, a, wd);
      use_lit = 1'b1;
      lit     = l;
      chk_rst = 1'b0;
      bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
      bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
      @(posedge clk); #1;
      acc_neg = neg_cyc;
      pending = 1'b1;
      bus.req_valid = 1'b0;
      repeat (exp_lat - 1 + hold) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      pending = 1'b0;
      exp_acc = exp_acc + CW'(1);
      if (st && !exp_err) ref_mem[a[7:2]] = exp_wword;
   endtask

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      int since;
      int rd_cnt, wr_cnt;
      rd_cnt = 0; wr_cnt = 0;
      forever begin
         @(negedge clk);
         neg_cyc++;
         since = neg_cyc - acc_neg;
         if (!reset && started) begin
            chk("mem_exclusive", 32'(bus.mem_read & bus.mem_write), 32'h0);
            chk("req_ready", 32'(bus.req_ready), 32'(!pending));
            if (pending) begin
               if (since == 1) begin rd_cnt = 0; wr_cnt = 0; end
               rd_cnt += int'(bus.mem_read);
               wr_cnt += int'(bus.mem_write);
               chk("rsp_valid", 32'(bus.rsp_valid), 32'(since >= exp_lat));
               if (bus.rsp_valid) begin
                  chk("rsp_data", bus.rsp_data, exp_data);
                  chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
                  if (use_lit) chk("rsp_literal", bus.rsp_data, lit);
               end
               if (bus.mem_read || bus.mem_write) chk("mem_addr", bus.mem_addr, exp_waddr);
               if (bus.mem_write) chk("mem_wdata", bus.mem_wdata, exp_wword);
               if (bus.rsp_valid && bus.rsp_ready) begin
                  chk("read_strobes", 32'(rd_cnt), 32'(exp_rd));
                  chk("write_strobes", 32'(wr_cnt), 32'(exp_wr));
                  if (use_lit) chk("model_literal", exp_data, lit);
               end
            end else begin
               chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
               chk("idle_rsp_data", bus.rsp_data, 32'h0);
               chk("idle_rsp_err", 32'(bus.rsp_err), 32'h0);
               chk("idle_mem_read", 32'(bus.mem_read), 32'h0);
               chk("idle_mem_write", 32'(bus.mem_write), 32'h0);
               if (chk_rst) begin
                  chk("rst_mem_addr", bus.mem_addr, 32'h0);
                  chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
               end
            end
            chk("acc_count", 32'(acc_count), 32'(exp_acc));
         end
      end
   end

   // Directed stimulus.
   initial begin
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_rst = 1'b1;
      started = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'h12F4_5678, 0, 32'h0);
      access(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, 0, 32'h0);
      access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 32'hFFFF_FFF4);
      access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 32'h0000_00F4);
      access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h0000_5678);
      access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0, 32'h0000_12F4);
      access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h0000_0078);
      access(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_0011, 0, 32'h0);
      access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 32'hAABB_11DD);
      access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'h0);
      access(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, 0, 32'h0);
      access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1, 32'h0);
      access(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 5, 32'h0);
      access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF);
      access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, 32'hFFFF_AABB);
      access(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE_1234, 0, 32'h0);
      access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 32'h0000_1234);
      // Sub-word store cut off by reset while its read strobe is up.
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h22; bus.req_wdata = 32'h99;
      exp_lat = 3;
      @(posedge clk); #1;
      acc_neg = neg_cyc;
      pending = 1'b1;
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      pending = 1'b0;
      chk_rst = 1'b1;
      exp_acc = '0;
      repeat (2) @(posedge clk);
      #1;
      access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 32'hAABB_11DD);
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
